// File: rtl/core_pkg.sv
// Shared core definitions.
// Purpose: datapath width, the canonical NOP word and the fetch-buffer entry
// layout used by the front end.
// Contents: XLEN, NOP_WORD, fb_entry_t, pc_misaligned().
package core_pkg;

  localparam int XLEN = 32;

  // addi x0, x0, 0
  localparam logic [XLEN-1:0] NOP_WORD = 32'h00000013;

  typedef struct packed {
    logic [XLEN-1:0] instr;
    logic [XLEN-1:0] pc;
    logic            misalign;
  } fb_entry_t;

  function automatic logic pc_misaligned(input logic [XLEN-1:0] pc);
    return |pc[1:0];
  endfunction

endpackage

// File: rtl/fetch_buffer_ctrl.sv
// Fetch buffer control: read/write pointers, entry count and handshakes.
// Ports:
//   clk, rst         clock, asynchronous active-low reset
//   in_valid_i       upstream word valid
//   out_ready_i      downstream consumes head entry
//   flush_i          discard all entries at the next edge
//   in_ready_o       room for another entry (count < DEPTH)
//   out_valid_o      head entry valid (count != 0)
//   push_o           a word is written this cycle
//   wr_ptr_o         slot written on push
//   rd_ptr_o         head slot
//   occupancy_o      current entry count
module fetch_buffer_ctrl #(
  parameter int DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid_i,
  input  logic                     out_ready_i,
  input  logic                     flush_i,
  output logic                     in_ready_o,
  output logic                     out_valid_o,
  output logic                     push_o,
  output logic [$clog2(DEPTH)-1:0] wr_ptr_o,
  output logic [$clog2(DEPTH)-1:0] rd_ptr_o,
  output logic [$clog2(DEPTH):0]   occupancy_o
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
  localparam logic [PW-1:0] PTR_ONE  = PW'(1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          pop;

  always_comb begin
    in_ready_o  = (count_q < FULL_CNT);
    out_valid_o = (count_q != '0);
    push_o      = in_valid_i & in_ready_o & ~flush_i;
    pop         = out_valid_o & out_ready_i & ~flush_i;

    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;

    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      // DEPTH is a power of two, so pointer overflow is the modulo wrap.
      if (push_o) wr_ptr_d = wr_ptr_q + PTR_ONE;
      if (pop)    rd_ptr_d = rd_ptr_q + PTR_ONE;
      case ({push_o, pop})
        2'b10:   count_d = count_q + CNT_ONE;
        2'b01:   count_d = count_q - CNT_ONE;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  assign wr_ptr_o    = wr_ptr_q;
  assign rd_ptr_o    = rd_ptr_q;
  assign occupancy_o = count_q;

endmodule

// File: rtl/fetch_buffer.sv
// Fetch buffer between instruction fetch and decode.
// Purpose: small circular queue of {instr, pc, misalign} entries with
// valid/ready handshakes on both sides and a flush for redirects.
// Ports:
//   clk, rst                    clock, asynchronous active-low reset
//   in_valid/in_ready           fetch-side handshake
//   in_instr, in_pc             fetched word and its PC
//   out_valid/out_ready         decode-side handshake
//   InstrD, PCD, PCPlus4D       head entry (NOP/0/0 when empty)
//   MisalignD                   head PC not word aligned
//   flush                       discard every entry
//   occupancy                   current entry count
module fetch_buffer
  import core_pkg::*;
#(
  parameter int              DEPTH     = 2,
  parameter logic [XLEN-1:0] NOP_INSTR = NOP_WORD
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [XLEN-1:0]        in_instr,
  input  logic [XLEN-1:0]        in_pc,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [XLEN-1:0]        InstrD,
  output logic [XLEN-1:0]        PCD,
  output logic [XLEN-1:0]        PCPlus4D,
  output logic                   MisalignD,
  input  logic                   flush,
  output logic [$clog2(DEPTH):0] occupancy
);

  localparam int PW = $clog2(DEPTH);

  logic          push;
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  fb_entry_t     mem_q [DEPTH];
  fb_entry_t     head;

  fetch_buffer_ctrl #(.DEPTH(DEPTH)) u_ctrl (
    .clk         (clk),
    .rst         (rst),
    .in_valid_i  (in_valid),
    .out_ready_i (out_ready),
    .flush_i     (flush),
    .in_ready_o  (in_ready),
    .out_valid_o (out_valid),
    .push_o      (push),
    .wr_ptr_o    (wr_ptr),
    .rd_ptr_o    (rd_ptr),
    .occupancy_o (occupancy)
  );

  // Storage is deliberately unreset; stale contents are masked while empty.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr] <= '{instr: in_instr, pc: in_pc, misalign: pc_misaligned(in_pc)};
    end
  end

  always_comb begin
    head      = mem_q[rd_ptr];
    InstrD    = NOP_INSTR;
    PCD       = '0;
    PCPlus4D  = '0;
    MisalignD = 1'b0;
    if (out_valid) begin
      InstrD    = head.instr;
      PCD       = head.pc;
      PCPlus4D  = head.pc + 32'd4;
      MisalignD = head.misalign;
    end
  end

endmodule

// File: tb/tb_fetch_buffer.sv
module tb_fetch_buffer;

  localparam int DEPTH = 2;
  localparam logic [31:0] NOP = 32'h00000013;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_instr = '0;
  logic [31:0] in_pc = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] InstrD, PCD, PCPlus4D;
  logic        MisalignD;
  logic        flush = 1'b0;
  logic [$clog2(DEPTH):0] occupancy;

  int checks = 0;
  int errors = 0;

  // Reference model: plain FIFO of accepted words.
  logic [31:0] mq_instr [$];
  logic [31:0] mq_pc    [$];

  fetch_buffer #(.DEPTH(DEPTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_instr  (in_instr),
    .in_pc     (in_pc),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .InstrD    (InstrD),
    .PCD       (PCD),
    .PCPlus4D  (PCPlus4D),
    .MisalignD (MisalignD),
    .flush     (flush),
    .occupancy (occupancy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic check_model();
    logic        v;
    logic [31:0] e_instr, e_pc, e_pc4;
    logic        e_mis;
    v       = (mq_instr.size() != 0);
    e_instr = NOP;
    e_pc    = '0;
    e_pc4   = '0;
    e_mis   = 1'b0;
    if (v) begin
      e_instr = mq_instr[0];
      e_pc    = mq_pc[0];
      e_pc4   = mq_pc[0] + 32'd4;
      e_mis   = (mq_pc[0] % 4) != 0;
    end
    check("out_valid", 32'(out_valid), 32'(v));
    check("in_ready",  32'(in_ready),  32'(mq_instr.size() < DEPTH));
    check("occupancy", 32'(occupancy), 32'(mq_instr.size()));
    check("InstrD",    InstrD,         e_instr);
    check("PCD",       PCD,            e_pc);
    check("PCPlus4D",  PCPlus4D,       e_pc4);
    check("MisalignD", 32'(MisalignD), 32'(e_mis));
  endtask

  task automatic drive(input logic v, input logic [31:0] ins, input logic [31:0] pc,
                       input logic ordy, input logic fl);
    in_valid  = v;
    in_instr  = ins;
    in_pc     = pc;
    out_ready = ordy;
    flush     = fl;
  endtask

  // Advance one clock, updating the model from the rules, then check at negedge.
  task automatic tick();
    bit do_push, do_pop, do_flush;
    do_flush = flush;
    do_push  = in_valid && (mq_instr.size() < DEPTH) && !flush;
    do_pop   = (mq_instr.size() != 0) && out_ready && !flush;
    @(posedge clk);
    if (do_flush) begin
      mq_instr.delete();
      mq_pc.delete();
    end else begin
      if (do_pop) begin
        void'(mq_instr.pop_front());
        void'(mq_pc.pop_front());
      end
      if (do_push) begin
        mq_instr.push_back(in_instr);
        mq_pc.push_back(in_pc);
      end
    end
    @(negedge clk);
    check_model();
  endtask

  initial begin
    // Reset state
    #1;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_in_ready",  32'(in_ready),  32'd1);
    check("rst_occupancy", 32'(occupancy), 32'd0);
    check("rst_InstrD",    InstrD,         NOP);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;

    // Single push, latency one
    drive(1, 32'h00500093, 32'h0, 0, 0);
    check("no_bypass_valid", 32'(out_valid), 32'd0);
    tick();
    check("first_InstrD",   InstrD,         32'h00500093);
    check("first_PCD",      PCD,            32'h0);
    check("first_PCPlus4D", PCPlus4D,       32'h4);
    check("first_valid",    32'(out_valid), 32'd1);

    // Fill, reject when full, stall holds head, then drain
    drive(1, 32'h00100113, 32'h4, 0, 0);
    tick();
    check("full_occ",   32'(occupancy), 32'd2);
    check("full_ready", 32'(in_ready),  32'd0);
    drive(1, 32'h00200193, 32'h8, 0, 0);
    tick();
    check("stall_PCD", PCD, 32'h0);
    check("stall_occ", 32'(occupancy), 32'd2);
    drive(0, 32'hdeadbeef, 32'h8, 1, 0);
    tick();
    check("drain1_PCD",   PCD,            32'h4);
    check("drain1_ready", 32'(in_ready),  32'd1);
    tick();
    check("drain2_valid", 32'(out_valid), 32'd0);

    // Full with push and pop together: pop only, then stream across wraps
    drive(1, 32'h11111111, 32'h100, 0, 0); tick();
    drive(1, 32'h22222222, 32'h104, 0, 0); tick();
    drive(1, 32'h33333333, 32'h108, 1, 0); tick();
    check("fullpp_occ", 32'(occupancy), 32'd1);
    check("fullpp_PCD", PCD, 32'h104);
    for (int i = 0; i < 10; i++) begin
      drive(1, 32'hA0000000 + 32'(i), 32'h200 + 32'(4 * i), 1, 0);
      tick();
    end
    drive(0, 0, 0, 1, 0); tick(); tick();
    check("wrap_empty", 32'(out_valid), 32'd0);

    // Flush with a concurrent push
    drive(1, 32'h44444444, 32'h300, 0, 0); tick();
    drive(1, 32'h55555555, 32'h304, 0, 0); tick();
    drive(1, 32'h66666666, 32'h308, 1, 1); tick();
    check("flush_occ",    32'(occupancy), 32'd0);
    check("flush_valid",  32'(out_valid), 32'd0);
    check("flush_InstrD", InstrD,         NOP);

    // Misaligned PC and PC+4 wrap
    drive(1, 32'h77777777, 32'h00000006, 0, 0); tick();
    check("misalign", 32'(MisalignD), 32'd1);
    drive(0, 0, 0, 1, 0); tick();
    drive(1, 32'h88888888, 32'hFFFFFFFC, 0, 0); tick();
    check("pc4_wrap", PCPlus4D, 32'h0);
    drive(0, 0, 0, 1, 0); tick();

    // Asynchronous reset mid-stream with a push pending
    drive(1, 32'h99999999, 32'h400, 0, 0); tick();
    check("pre_rst_occ", 32'(occupancy), 32'd1);
    drive(1, 32'hAAAAAAAA, 32'h404, 0, 0);
    #2 rst = 1'b0;
    #1;
    check("arst_valid",  32'(out_valid), 32'd0);
    check("arst_ready",  32'(in_ready),  32'd1);
    check("arst_occ",    32'(occupancy), 32'd0);
    check("arst_InstrD", InstrD,         NOP);
    mq_instr.delete();
    mq_pc.delete();
    @(negedge clk);
    rst = 1'b1;
    drive(1, 32'hBBBBBBBB, 32'h500, 0, 0); tick();
    check("post_rst_InstrD", InstrD, 32'hBBBBBBBB);
    check("post_rst_occ", 32'(occupancy), 32'd1);

    // Randomized traffic against the model
    for (int i = 0; i < 600; i++) begin
      drive($urandom_range(0, 3) != 0, $urandom, $urandom,
            $urandom_range(0, 2) != 0, $urandom_range(0, 19) == 0);
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/fetch_buffer.md
FETCH_BUFFER -- requirements
Module: fetch_buffer

Interface
REQ-001 SHALL have parameter DEPTH, default 2: number of instruction entries, power of two, 2..8.
REQ-002 SHALL have parameter NOP_INSTR, default 32'h00000013: word driven on InstrD when empty (addi x0,x0,0).
REQ-003 SHALL have port clk, input, 1: sole clock, rising edge.
REQ-004 SHALL have port rst, input, 1: reset, asynchronous assert, active-low.
REQ-005 SHALL have port in_valid, input, 1: fetch word and PC valid.
REQ-006 SHALL have port in_ready, output, 1: buffer accepts a word this cycle.
REQ-007 SHALL have port in_instr, input, 32: fetched instruction word.
REQ-008 SHALL have port in_pc, input, 32: PC of in_instr.
REQ-009 SHALL have port out_valid, output, 1: InstrD/PCD hold a valid entry.
REQ-010 SHALL have port out_ready, input, 1: decode consumes the head entry (low = decode stall).
REQ-011 SHALL have port InstrD, output, 32: head instruction, feeds decode and the immediate generator In port.
REQ-012 SHALL have port PCD, output, 32: head PC.
REQ-013 SHALL have port PCPlus4D, output, 32: PCD + 4, modulo 2^32.
REQ-014 SHALL have port MisalignD, output, 1: head PC has bits [1:0] nonzero.
REQ-015 SHALL have port flush, input, 1: branch/jump redirect; discard all entries.
REQ-016 SHALL have port occupancy, output, $clog2(DEPTH)+1: current entry count.

Function
REQ-017 SHALL store entries {instr, pc, misalign} in a circular buffer with write pointer, read pointer and count.
REQ-018 SHALL drive in_ready = (count < DEPTH), independent of out_ready and flush.
REQ-019 SHALL push on a rising edge when in_valid & in_ready & ~flush; misalign = |in_pc[1:0].
REQ-020 SHALL pop on a rising edge when out_valid & out_ready & ~flush.
REQ-021 SHALL drive out_valid = (count != 0); InstrD/PCD/PCPlus4D/MisalignD are combinational from the head entry.
REQ-022 SHALL drive InstrD = NOP_INSTR, PCD = 0, PCPlus4D = 0, MisalignD = 0 while count == 0.
REQ-023 SHALL give latency 1: a word pushed at edge N is visible on InstrD after edge N; no input-to-output bypass.
REQ-024 SHALL, on simultaneous push and pop, leave count unchanged and advance both pointers.
REQ-025 SHALL wrap pointers modulo DEPTH.
REQ-026 SHALL, on flush, set count = 0 and both pointers = 0 at the next edge, discarding any same-cycle push and pop.
REQ-027 SHALL hold head outputs stable while out_valid & ~out_ready & ~flush.
REQ-028 SHALL ignore in_instr/in_pc contents when in_valid = 0, and never accept a push while full.

Reset
REQ-029 SHALL, on rst low, asynchronously clear count and pointers; out_valid = 0, in_ready = 1, occupancy = 0, InstrD = NOP_INSTR.
REQ-030 SHALL leave entry storage unreset; outputs are masked by REQ-022.
REQ-031 SHALL discard a push in progress when reset asserts mid-cycle; the first accepted push after release is entry 0.

Structure
REQ-032 SHALL take XLEN = 32 and the NOP constant from shared package core_pkg.
REQ-033 SHALL keep pointer/count/ready/valid logic in one sub-module fetch_buffer_ctrl; storage and output muxing stay in fetch_buffer.

Verification
REQ-034 Reset then push in_instr=32'h00500093, in_pc=32'h0 -> next cycle out_valid=1, InstrD=32'h00500093, PCD=0, PCPlus4D=4.
REQ-035 out_ready=0, push PCs 0x0, 0x4 -> occupancy=2, in_ready=0; third word at 0x8 not accepted; out_ready=1 -> drains 0x0 then 0x4, in_ready=1.
REQ-036 Full (DEPTH=2), in_valid=1 and out_ready=1 same cycle -> pop only; next cycle push accepted; order preserved across pointer wrap over 10 words.
REQ-037 Occupancy 2, flush=1 with in_valid=1 -> next cycle occupancy=0, out_valid=0, InstrD=32'h00000013.
REQ-038 Push in_pc=32'h00000006 -> MisalignD=1 when that entry reaches the head.
REQ-039 Assert rst low mid-stream with occupancy 1 -> immediately out_valid=0, in_ready=1, InstrD=NOP; after release, first push appears at head.
